led_fade_pwm: RTL and testbench



---
 rtl/led_fade_pwm_pkg.sv | 26 ++
 rtl/led_fade_chan.sv | 80 ++++++++
 rtl/led_fade_pwm.sv | 80 ++++++++
 tb/tb_led_fade_pwm.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_fade_pwm_pkg.sv
// Shared definitions for the LED fade/PWM stage: channel state encodings and MiscReg field positions.
// Included by led_fade_chan and led_fade_pwm.
package led_fade_pwm_pkg;

   typedef enum logic [1:0] {
      LED_CH_OFF  = 2'd0,
      LED_CH_UP   = 2'd1,
      LED_CH_ON   = 2'd2,
      LED_CH_DOWN = 2'd3
   } led_ch_e;

   localparam int LED_LEVEL_BITS = 8;

   // MiscReg field positions written by pifctl.
   localparam int MISC_BRIGHT_LSB  = 0;
   localparam int MISC_BRIGHT_MSB  = MISC_BRIGHT_LSB + LED_LEVEL_BITS - 1;
   localparam int MISC_RAMP_EN_BIT = MISC_BRIGHT_MSB + 1;

   function automatic led_ch_e led_ch_classify(input logic [31:0] level, input logic [31:0] target);
      if (level < target)      return LED_CH_UP;
      else if (level > target) return LED_CH_DOWN;
      else if (target != 0)    return LED_CH_ON;
      else                     return LED_CH_OFF;
   endfunction

endpackage

// File: rtl/led_fade_chan.sv
// One LED channel: ramp FSM, level register, duty latch (square-law map when LED_FADE_GAMMA_EN) and PWM output flop.
// Latency: level 1 cycle, duty at next PWM period, drive 1 cycle after compare; no backpressure.
module led_fade_chan
   import led_fade_pwm_pkg::*;
#(
   parameter int PWM_BITS  = 8,
   parameter int RAMP_STEP = 4
) (
   input  logic                xclk,
   input  logic                sys_rst,
   input  logic                req_i,
   input  logic [PWM_BITS-1:0] bright_i,
   input  logic                ramp_en_i,
   input  logic                tick_i,
   input  logic [PWM_BITS-1:0] cnt_i,
   input  logic                cnt_wrap_i,
   output logic                out_o,
   output led_ch_e             state_o
);

   localparam int W = PWM_BITS;
   localparam logic [W:0] STEP_EXT = (W+1)'(RAMP_STEP);

   logic [W-1:0] target;
   logic [W-1:0] level_q, level_d;
   logic [W-1:0] duty_q, duty_src;
   logic [W:0]   up_sum, dn_diff;
   led_ch_e      state_q, state_d;
   logic         out_q, out_d;

   assign target  = req_i ? bright_i : '0;
   assign up_sum  = {1'b0, level_q} + STEP_EXT;
   assign dn_diff = {1'b0, level_q} - STEP_EXT;

   // Direction follows the live comparison so a mid-ramp target change redirects at once.
   always_comb begin
      level_d = level_q;
      state_d = LED_CH_OFF;
      if (!ramp_en_i) begin
         level_d = target;
      end else if (tick_i) begin
         if (level_q < target) begin
            level_d = (up_sum > {1'b0, target}) ? target : up_sum[W-1:0];
         end else if (level_q > target) begin
            level_d = (dn_diff[W] || (dn_diff[W-1:0] < target)) ? target : dn_diff[W-1:0];
         end
      end
      state_d = led_ch_classify(32'(level_d), 32'(target));
   end

`ifdef LED_FADE_GAMMA_EN
   logic [2*W-1:0] level_sq;
   assign level_sq = {{W{1'b0}}, level_q} * {{W{1'b0}}, level_q};
   assign duty_src = (&level_q) ? '1 : level_sq[2*W-1:W];
`else
   assign duty_src = level_q;
`endif

   assign out_d = (&duty_q) | (cnt_i < duty_q);

   always_ff @(posedge xclk or negedge sys_rst) begin
      if (!sys_rst) begin
         level_q <= '0;
         state_q <= LED_CH_OFF;
         duty_q  <= '0;
         out_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         state_q <= state_d;
         if (cnt_wrap_i) begin
            duty_q <= duty_src;
         end
         out_q   <= out_d;
      end
   end

   assign out_o   = out_q;
   assign state_o = state_q;

endmodule

// File: rtl/led_fade_pwm.sv
// Red/green soft-ramped PWM LED driver; owns ramp tick divider, PWM counter and busy (gamma via LED_FADE_GAMMA_EN).
// Latency: all outputs registered, 1 cycle; free-running, no backpressure.
module led_fade_pwm
   import led_fade_pwm_pkg::*;
#(
   parameter int PWM_BITS  = 8,
   parameter int RAMP_DIV  = 256,
   parameter int RAMP_STEP = 4
) (
   input  logic                xclk,
   input  logic                sys_rst,
   input  logic                led_r_req,
   input  logic                led_g_req,
   input  logic [PWM_BITS-1:0] bright,
   input  logic                ramp_en,
   output logic                led_r_out,
   output logic                led_g_out,
   output logic                busy
);

   localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

   logic [DIV_W-1:0]    div_q, div_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                tick, cnt_wrap;
   led_ch_e             st_r, st_g;

   assign tick     = (div_q == DIV_LAST);
   assign cnt_wrap = &cnt_q;

   always_comb begin
      div_d  = tick ? '0 : div_q + DIV_W'(1);
      cnt_d  = cnt_q + PWM_BITS'(1);
      busy_d = (st_r == LED_CH_UP) | (st_r == LED_CH_DOWN) |
               (st_g == LED_CH_UP) | (st_g == LED_CH_DOWN);
   end

   always_ff @(posedge xclk or negedge sys_rst) begin
      if (!sys_rst) begin
         div_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   led_fade_chan #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_chan_r (
      .xclk       (xclk),
      .sys_rst    (sys_rst),
      .req_i      (led_r_req),
      .bright_i   (bright),
      .ramp_en_i  (ramp_en),
      .tick_i     (tick),
      .cnt_i      (cnt_q),
      .cnt_wrap_i (cnt_wrap),
      .out_o      (led_r_out),
      .state_o    (st_r)
   );

   led_fade_chan #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_chan_g (
      .xclk       (xclk),
      .sys_rst    (sys_rst),
      .req_i      (led_g_req),
      .bright_i   (bright),
      .ramp_en_i  (ramp_en),
      .tick_i     (tick),
      .cnt_i      (cnt_q),
      .cnt_wrap_i (cnt_wrap),
      .out_o      (led_g_out),
      .state_o    (st_g)
   );

   assign busy = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Scoreboard bench for led_fade_pwm: stimulus queues cycle-stamped expectations, monitors compare them.
module tb_led_fade_pwm;

   localparam int K_VAL  = 0;
   localparam int K_MARK = 1;
   localparam int K_HI   = 2;

   localparam int S_LED_R   = 0;
   localparam int S_LED_G   = 1;
   localparam int S_BUSY    = 2;
   localparam int S_LEVEL_R = 3;
   localparam int S_LEVEL_G = 4;
   localparam int S_STATE_R = 5;
   localparam int S_STATE_G = 6;

   localparam int ST_OFF = 0, ST_UP = 1, ST_ON = 2, ST_DOWN = 3;

`ifdef LED_FADE_GAMMA_EN
   localparam int HI_80 = 64;
`else
   localparam int HI_80 = 128;
`endif

   logic       xclk, sys_rst, led_r_req, led_g_req, ramp_en;
   logic [7:0] bright;
   logic       led_r_out, led_g_out, busy;

   led_fade_pwm #(.PWM_BITS(8), .RAMP_DIV(4), .RAMP_STEP(4)) dut (
      .xclk      (xclk),
      .sys_rst   (sys_rst),
      .led_r_req (led_r_req),
      .led_g_req (led_g_req),
      .bright    (bright),
      .ramp_en   (ramp_en),
      .led_r_out (led_r_out),
      .led_g_out (led_g_out),
      .busy      (busy)
   );

   typedef struct {
      int    due;
      int    kind;
      int    sel;
      int    expv;
      string name;
   } exp_t;

   typedef struct {
      int    sel;
      int    expv;
      string name;
   } aexp_t;

   exp_t  sb_q[$];
   aexp_t async_q[$];

   int cyc    = 0;
   int passed = 0;
   int total  = 0;
   int hi_r   = 0;
   int hi_g   = 0;
   int mark_r = 0;
   int mark_g = 0;

   initial begin
      xclk = 1'b0;
      forever #5 xclk = ~xclk;
   end

   function automatic int sig_val(input int sel);
      case (sel)
         S_LED_R:   return int'(led_r_out);
         S_LED_G:   return int'(led_g_out);
         S_BUSY:    return int'(busy);
         S_LEVEL_R: return int'(dut.u_chan_r.level_q);
         S_LEVEL_G: return int'(dut.u_chan_g.level_q);
         S_STATE_R: return int'(dut.u_chan_r.state_q);
         S_STATE_G: return int'(dut.u_chan_g.state_q);
         default:   return -1;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int expv);
      total = total + 1;
      if (act == expv) passed = passed + 1;
      else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, expv, cyc);
   endtask

   task automatic expect_at(input int due, input int kind, input int sel, input int expv, input string name);
      exp_t e;
      e.due  = due;
      e.kind = kind;
      e.sel  = sel;
      e.expv = expv;
      e.name = name;
      sb_q.push_back(e);
   endtask

   task automatic expect_async(input int sel, input int expv, input string name);
      aexp_t a;
      a.sel  = sel;
      a.expv = expv;
      a.name = name;
      async_q.push_back(a);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge xclk);
   endtask

   // Clocked monitor: samples 1 time unit after each rising edge.
   always @(posedge xclk) begin : mon
      exp_t keep[$];
      #1;
      cyc = cyc + 1;
      if (led_r_out) hi_r = hi_r + 1;
      if (led_g_out) hi_g = hi_g + 1;
      keep = {};
      foreach (sb_q[i]) begin
         if (sb_q[i].due > cyc) begin
            keep.push_back(sb_q[i]);
         end else if (sb_q[i].due < cyc) begin
            total = total + 1;
            $display("FAIL %s: expectation for cycle %0d missed (now %0d)", sb_q[i].name, sb_q[i].due, cyc);
         end else if (sb_q[i].kind == K_MARK) begin
            if (sb_q[i].sel == S_LED_R) mark_r = hi_r;
            else                        mark_g = hi_g;
         end else if (sb_q[i].kind == K_HI) begin
            check(sb_q[i].name, (sb_q[i].sel == S_LED_R) ? (hi_r - mark_r) : (hi_g - mark_g), sb_q[i].expv);
         end else begin
            check(sb_q[i].name, sig_val(sb_q[i].sel), sb_q[i].expv);
         end
      end
      sb_q = keep;
   end

   // Reset monitor: checks state shortly after reset asserts, between clock edges.
   always @(negedge sys_rst) begin : amon
      aexp_t a;
      #1;
      while (async_q.size() > 0) begin
         a = async_q.pop_front();
         check(a.name, sig_val(a.sel), a.expv);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int r, r2, r3;
      sys_rst   = 1'b0;
      led_r_req = 1'b0;
      led_g_req = 1'b0;
      ramp_en   = 1'b0;
      bright    = 8'h00;

      expect_at(2, K_VAL, S_LED_R,   0,      "rst_led_r");
      expect_at(2, K_VAL, S_LED_G,   0,      "rst_led_g");
      expect_at(2, K_VAL, S_BUSY,    0,      "rst_busy");
      expect_at(2, K_VAL, S_LEVEL_R, 0,      "rst_level_r");
      expect_at(2, K_VAL, S_STATE_R, ST_OFF, "rst_state_r");

      // Jump mode, half brightness on red.
      wait_cyc(3);
      r = cyc;
      sys_rst   = 1'b1;
      ramp_en   = 1'b0;
      bright    = 8'h80;
      led_r_req = 1'b1;
      expect_at(r+1,   K_VAL,  S_LEVEL_R, 8'h80, "jump_level_r");
      expect_at(r+1,   K_VAL,  S_STATE_R, ST_ON, "jump_state_r");
      expect_at(r+1,   K_VAL,  S_BUSY,    0,     "jump_busy");
      expect_at(r+200, K_VAL,  S_LED_R,   0,     "duty_waits_for_period");
      expect_at(r+256, K_MARK, S_LED_R,   0,     "");
      expect_at(r+256, K_MARK, S_LED_G,   0,     "");
      expect_at(r+512, K_HI,   S_LED_R,   HI_80, "half_hi_period1");
      expect_at(r+512, K_HI,   S_LED_G,   0,     "green_idle_hi");
      expect_at(r+512, K_MARK, S_LED_R,   0,     "");
      expect_at(r+768, K_HI,   S_LED_R,   HI_80, "half_hi_period2");

      // Full brightness: constant high.
      wait_cyc(r+768);
      bright = 8'hFF;
      expect_at(r+769,  K_VAL,  S_LEVEL_R, 255, "full_level_r");
      expect_at(r+1024, K_MARK, S_LED_R,   0,   "");
      expect_at(r+1280, K_HI,   S_LED_R,   256, "full_hi");

      // Zero brightness with request: constant low, OFF.
      wait_cyc(r+1280);
      bright = 8'h00;
      expect_at(r+1281, K_VAL,  S_STATE_R, ST_OFF, "zero_state_off");
      expect_at(r+1281, K_VAL,  S_LEVEL_R, 0,      "zero_level_r");
      expect_at(r+1536, K_MARK, S_LED_R,   0,      "");
      expect_at(r+1792, K_HI,   S_LED_R,   0,      "zero_hi");

      // Ramp mode from a fresh reset so the tick phase is known.
      wait_cyc(r+1800);
      sys_rst   = 1'b0;
      ramp_en   = 1'b1;
      bright    = 8'h10;
      led_r_req = 1'b1;
      led_g_req = 1'b0;
      wait_cyc(r+1803);
      r2 = cyc;
      sys_rst = 1'b1;
      expect_at(r2+1,  K_VAL, S_BUSY,    0,     "ramp_busy_lag");
      expect_at(r2+2,  K_VAL, S_BUSY,    1,     "ramp_busy_up");
      expect_at(r2+3,  K_VAL, S_LEVEL_R, 0,     "ramp_level_pre_tick");
      expect_at(r2+4,  K_VAL, S_LEVEL_R, 4,     "ramp_level_4");
      expect_at(r2+4,  K_VAL, S_STATE_R, ST_UP, "ramp_state_up");
      expect_at(r2+8,  K_VAL, S_LEVEL_R, 8,     "ramp_level_8");
      expect_at(r2+12, K_VAL, S_LEVEL_R, 12,    "ramp_level_12");
      expect_at(r2+16, K_VAL, S_LEVEL_R, 16,    "ramp_level_16");
      expect_at(r2+16, K_VAL, S_STATE_R, ST_ON, "ramp_state_on");
      expect_at(r2+16, K_VAL, S_BUSY,    1,     "ramp_busy_last");
      expect_at(r2+17, K_VAL, S_BUSY,    0,     "ramp_busy_clear");

      // Green rises, then drops at level 8 mid-ramp.
      wait_cyc(r2+16);
      led_g_req = 1'b1;
      expect_at(r2+17, K_VAL, S_STATE_G, ST_UP,   "g_state_up");
      expect_at(r2+24, K_VAL, S_LEVEL_G, 8,       "g_level_8");
      wait_cyc(r2+24);
      led_g_req = 1'b0;
      expect_at(r2+28, K_VAL, S_LEVEL_G, 4,       "g_drop_level_4");
      expect_at(r2+28, K_VAL, S_STATE_G, ST_DOWN, "g_state_down");
      expect_at(r2+32, K_VAL, S_LEVEL_G, 0,       "g_level_0");
      expect_at(r2+32, K_VAL, S_STATE_G, ST_OFF,  "g_state_off");
      expect_at(r2+32, K_VAL, S_LEVEL_R, 16,      "r_independent");
      expect_at(r2+33, K_VAL, S_BUSY,    0,       "busy_after_g_off");

      // Red ramps toward 0x80; reset hits at level 0x40.
      wait_cyc(r2+32);
      bright = 8'h80;
      expect_at(r2+80, K_VAL, S_LEVEL_R, 8'h40, "r_level_40");
      expect_at(r2+80, K_VAL, S_BUSY,    1,     "r_busy_mid_ramp");
      wait_cyc(r2+80);
      expect_async(S_LEVEL_R, 0,      "arst_level_r");
      expect_async(S_STATE_R, ST_OFF, "arst_state_r");
      expect_async(S_BUSY,    0,      "arst_busy");
      expect_async(S_LED_R,   0,      "arst_led_r");
      sys_rst = 1'b0;
      expect_at(r2+81, K_VAL, S_BUSY, 0, "rst_held_busy");
      wait_cyc(r2+83);
      r3 = cyc;
      sys_rst = 1'b1;
      expect_at(r3+1, K_VAL, S_LEVEL_R, 0,     "restart_level_0");
      expect_at(r3+1, K_VAL, S_STATE_R, ST_UP, "restart_state_up");
      expect_at(r3+3, K_VAL, S_LEVEL_R, 0,     "restart_pre_tick");
      expect_at(r3+4, K_VAL, S_LEVEL_R, 4,     "restart_level_4");

      for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge xclk);
      if (sb_q.size() != 0) begin
         total = total + sb_q.size();
         $display("FAIL scoreboard_drain: %0d expectations never reached", sb_q.size());
      end
      if (async_q.size() != 0) begin
         total = total + async_q.size();
         $display("FAIL async_drain: %0d reset expectations never checked", async_q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
